// File: rtl/vx_commit_arb_pkg.sv
// Shared definitions for the commit arbiter: payload layout, flag bit offsets,
// performance counter width and a select-width helper.
package vx_commit_arb_pkg;

    localparam int COMMIT_EOP_BIT = 0;
    localparam int COMMIT_SOP_BIT = 1;
    localparam int PERF_CTR_BITS  = 44;

    // Default 128-bit commit packet; eop lands on bit 0 and sop on bit 1.
    typedef struct packed {
        logic [14:0] uuid;
        logic [3:0]  wid;
        logic [3:0]  tmask;
        logic [31:0] pc;
        logic        wb;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [0:0]  pid;
        logic        sop;
        logic        eop;
    } commit_data_t;

    localparam int COMMIT_DATAW = $bits(commit_data_t);

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } lock_state_e;

    // Index width for n requesters; a single requester still gets one bit.
    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_rr_lock_arbiter.sv
// Round-robin arbiter with packet locking: once a requester starts a multi-beat
// packet it owns the grant until the beat carrying eop is accepted.
module vx_rr_lock_arbiter
    import vx_commit_arb_pkg::*;
#(
    parameter int  NUM_REQS = 4,
    localparam int SEL_W    = log2up(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] requests,
    input  logic                fire,
    input  logic                sop,
    input  logic                eop,
    output logic [NUM_REQS-1:0] grant,
    output logic [SEL_W-1:0]    grant_idx,
    output logic                locked
);

    lock_state_e      state, state_n;
    logic [SEL_W-1:0] rr_ptr, rr_ptr_n;
    logic [SEL_W-1:0] lock_idx, lock_idx_n;
    logic [SEL_W:0]   probe;
    logic [SEL_W-1:0] pick;
    logic             found;

    assign locked = (state == ARB_LOCKED);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        probe     = '0;
        pick      = '0;
        found     = 1'b0;
        if (state == ARB_LOCKED) begin
            grant_idx       = lock_idx;
            grant[lock_idx] = requests[lock_idx];
        end else begin
            for (int k = 0; k < NUM_REQS; k++) begin
                probe = {1'b0, rr_ptr} + (SEL_W+1)'(k);
                if (probe >= (SEL_W+1)'(NUM_REQS)) begin
                    probe = probe - (SEL_W+1)'(NUM_REQS);
                end
                if (!found && requests[probe[SEL_W-1:0]]) begin
                    found = 1'b1;
                    pick  = probe[SEL_W-1:0];
                end
            end
            grant_idx   = pick;
            grant[pick] = found;
        end
    end

    always_comb begin
        state_n    = state;
        rr_ptr_n   = rr_ptr;
        lock_idx_n = lock_idx;
        if (fire) begin
            rr_ptr_n = (grant_idx == SEL_W'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
            unique case (state)
                ARB_OPEN: begin
                    if (sop && !eop) begin
                        state_n    = ARB_LOCKED;
                        lock_idx_n = grant_idx;
                    end
                end
                ARB_LOCKED: begin
                    if (eop) begin
                        state_n = ARB_OPEN;
                    end
                end
                default: state_n = ARB_OPEN;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB_OPEN;
            rr_ptr   <= '0;
            lock_idx <= '0;
        end else begin
            state    <= state_n;
            rr_ptr   <= rr_ptr_n;
            lock_idx <= lock_idx_n;
        end
    end

`ifndef SYNTHESIS
    // A beat accepted outside a packet must open one.
    a_sop_when_open: assert property (@(posedge clk) disable iff (reset)
        (fire && state == ARB_OPEN) |-> sop);
`endif

endmodule

// File: rtl/vx_commit_arb.sv
// Commit arbiter: merges NUM_REQS execution-unit commit streams onto one channel,
// optionally through a one-entry output register. Define VX_COMMIT_ARB_PERF_EN for perf counters.
module vx_commit_arb
    import vx_commit_arb_pkg::*;
#(
    parameter int  NUM_REQS = 4,
    parameter int  DATAW    = COMMIT_DATAW,
    parameter int  OUT_BUF  = 1,
    localparam int SEL_W    = log2up(NUM_REQS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       in_valid,
    input  logic [NUM_REQS*DATAW-1:0] in_data,
    output logic [NUM_REQS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [DATAW-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    input  logic                      out_ready
`ifdef VX_COMMIT_ARB_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0]  perf_stall_cycles,
    output logic [PERF_CTR_BITS-1:0]  perf_commits
`endif
);

    logic [NUM_REQS-1:0] grant;
    logic [SEL_W-1:0]    grant_idx;
    logic                locked;
    logic [DATAW-1:0]    sel_data;
    logic                en;
    logic                fire;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                sel_data = in_data[i*DATAW +: DATAW];
            end
        end
    end

    // Nothing is accepted while reset is held, even if requesters keep valid high.
    assign in_ready = (en && !reset) ? grant : '0;
    assign fire     = |(in_valid & in_ready);

    vx_rr_lock_arbiter #(
        .NUM_REQS (NUM_REQS)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .requests  (in_valid),
        .fire      (fire),
        .sop       (sel_data[COMMIT_SOP_BIT]),
        .eop       (sel_data[COMMIT_EOP_BIT]),
        .grant     (grant),
        .grant_idx (grant_idx),
        .locked    (locked)
    );

    generate
        if (OUT_BUF != 0) begin : g_buf
            logic             valid_q;
            logic [DATAW-1:0] data_q;
            logic [SEL_W-1:0] sel_q;

            // The slot may refill in the same cycle it drains.
            assign en = !valid_q || out_ready;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    sel_q   <= '0;
                end else if (fire) begin
                    valid_q <= 1'b1;
                    data_q  <= sel_data;
                    sel_q   <= grant_idx;
                end else if (out_ready) begin
                    valid_q <= 1'b0;
                end
            end

            assign out_valid = valid_q;
            assign out_data  = data_q;
            assign out_sel   = sel_q;
        end else begin : g_pass
            assign en        = out_ready;
            assign out_valid = |(in_valid & grant) && !reset;
            assign out_data  = sel_data;
            assign out_sel   = grant_idx;
        end
    endgenerate

`ifdef VX_COMMIT_ARB_PERF_EN
    logic [PERF_CTR_BITS-1:0] stall_q;
    logic [PERF_CTR_BITS-1:0] commits_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q   <= '0;
            commits_q <= '0;
        end else begin
            if (out_valid && !out_ready && !(&stall_q)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (out_valid && out_ready && out_data[COMMIT_EOP_BIT] && !(&commits_q)) begin
                commits_q <= commits_q + 1'b1;
            end
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_commits      = commits_q;
`endif

`ifndef SYNTHESIS
    a_one_ready: assert property (@(posedge clk) disable iff (reset) $onehot0(in_ready));
    a_lock_owner: assert property (@(posedge clk) disable iff (reset)
        (locked && fire) |-> in_ready[grant_idx]);
`endif

endmodule

// File: tb/tb_vx_commit_arb.sv
// Directed bench for vx_commit_arb: a cycle table for round-robin and locking,
// plus hand-written backpressure, async-reset and (optional) perf-counter sequences.
module tb_vx_commit_arb;
    import vx_commit_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 128;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_sel;
    logic            out_ready;
`ifdef VX_COMMIT_ARB_PERF_EN
    logic [PERF_CTR_BITS-1:0] perf_stall_cycles;
    logic [PERF_CTR_BITS-1:0] perf_commits;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vx_commit_arb #(
        .NUM_REQS (N),
        .DATAW    (DW),
        .OUT_BUF  (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
`ifdef VX_COMMIT_ARB_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_commits      (perf_commits)
`endif
    );

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic       rdy;
        logic [7:0] fl;        // {sop,eop} per requester, requester i at [2i+:2]
        logic [3:0] exp_ready;
        logic       exp_ov;
        logic [1:0] exp_sel;
        logic [1:0] exp_fl;    // {sop,eop} of the beat expected on out_data
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [13:0] tag, input logic sop, input logic eop);
        return {112'h0, tag, sop, eop};
    endfunction

    task automatic set_req(input int i, input logic [13:0] tag, input logic sop, input logic eop);
        in_data[i*DW +: DW] = mk(tag, sop, eop);
    endtask

    task automatic v(input logic rst, input logic [3:0] valid, input logic rdy, input logic [7:0] fl,
                     input logic [3:0] exp_ready, input logic exp_ov, input logic [1:0] exp_sel,
                     input logic [1:0] exp_fl);
        vec_t r;
        r.rst = rst; r.valid = valid; r.rdy = rdy; r.fl = fl;
        r.exp_ready = exp_ready; r.exp_ov = exp_ov; r.exp_sel = exp_sel; r.exp_fl = exp_fl;
        vq.push_back(r);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_reset();
        next_cycle();
        reset    = 1'b1;
        in_valid = '0;
        out_ready = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset with everyone valid, then single-beat round robin 0,1,2,3,0,1.
        v(1'b1, 4'hF, 1'b1, 8'hFF, 4'h0, 1'b0, 2'd0, 2'b00);
        v(1'b1, 4'hF, 1'b1, 8'hFF, 4'h0, 1'b0, 2'd0, 2'b00);
        v(1'b0, 4'hF, 1'b1, 8'hFF, 4'h1, 1'b0, 2'd0, 2'b00);
        v(1'b0, 4'hF, 1'b1, 8'hFF, 4'h2, 1'b1, 2'd0, 2'b11);
        v(1'b0, 4'hF, 1'b1, 8'hFF, 4'h4, 1'b1, 2'd1, 2'b11);
        v(1'b0, 4'hF, 1'b1, 8'hFF, 4'h8, 1'b1, 2'd2, 2'b11);
        v(1'b0, 4'hF, 1'b1, 8'hFF, 4'h1, 1'b1, 2'd3, 2'b11);
        v(1'b0, 4'hF, 1'b1, 8'hFF, 4'h2, 1'b1, 2'd0, 2'b11);
        v(1'b0, 4'hF, 1'b1, 8'hFF, 4'h4, 1'b1, 2'd1, 2'b11);
        // req1 sends sop / mid / (idle) / eop while req0 and req2 wait.
        v(1'b1, 4'h7, 1'b1, 8'h3B, 4'h0, 1'b0, 2'd0, 2'b00);
        v(1'b0, 4'h7, 1'b1, 8'h3B, 4'h1, 1'b0, 2'd0, 2'b00);
        v(1'b0, 4'h7, 1'b1, 8'h3B, 4'h2, 1'b1, 2'd0, 2'b11);
        v(1'b0, 4'h7, 1'b1, 8'h33, 4'h2, 1'b1, 2'd1, 2'b10);
        v(1'b0, 4'h5, 1'b1, 8'h33, 4'h0, 1'b1, 2'd1, 2'b00);
        v(1'b0, 4'h7, 1'b1, 8'h37, 4'h2, 1'b0, 2'd0, 2'b00);
        v(1'b0, 4'h5, 1'b1, 8'h37, 4'h4, 1'b1, 2'd1, 2'b01);
        v(1'b0, 4'h5, 1'b1, 8'h37, 4'h1, 1'b1, 2'd2, 2'b11);
        v(1'b0, 4'h5, 1'b1, 8'h37, 4'h4, 1'b1, 2'd0, 2'b11);

        foreach (vq[k]) begin
            next_cycle();
            reset     = vq[k].rst;
            in_valid  = vq[k].valid;
            out_ready = vq[k].rdy;
            for (int i = 0; i < N; i++) begin
                logic [7:0] f;
                f = vq[k].fl >> (2 * i);
                set_req(i, 14'(16 + i), f[1], f[0]);
            end
            @(negedge clk);
            check($sformatf("v%0d in_ready", k), 128'(in_ready), 128'(vq[k].exp_ready));
            check($sformatf("v%0d out_valid", k), 128'(out_valid), 128'(vq[k].exp_ov));
            if (vq[k].exp_ov) begin
                check($sformatf("v%0d out_sel", k), 128'(out_sel), 128'(vq[k].exp_sel));
                check($sformatf("v%0d out_data", k), 128'(out_data),
                      128'(mk(14'(16 + vq[k].exp_sel), vq[k].exp_fl[1], vq[k].exp_fl[0])));
            end
            if (vq[k].rst) begin
                check($sformatf("v%0d rst out_data", k), 128'(out_data), 128'(0));
                check($sformatf("v%0d rst out_sel", k), 128'(out_sel), 128'(0));
            end
        end

        // Backpressure: beat A held in the output slot, B waits, then A,B,C in order.
        sync_reset();
        out_ready = 1'b0;
        in_valid  = 4'h8;
        set_req(3, 14'hA1, 1'b1, 1'b1);
        @(negedge clk);
        check("bp first in_ready", 128'(in_ready), 128'(4'h8));
        check("bp first out_valid", 128'(out_valid), 128'(0));
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            set_req(3, 14'hB2, 1'b1, 1'b1);
            @(negedge clk);
            check($sformatf("bp hold%0d in_ready", c), 128'(in_ready), 128'(0));
            check($sformatf("bp hold%0d out_valid", c), 128'(out_valid), 128'(1));
            check($sformatf("bp hold%0d out_data", c), 128'(out_data), 128'(mk(14'hA1, 1'b1, 1'b1)));
        end
        check("bp out_sel", 128'(out_sel), 128'(3));
        next_cycle();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp resume in_ready", 128'(in_ready), 128'(4'h8));
        check("bp resume A", 128'(out_data), 128'(mk(14'hA1, 1'b1, 1'b1)));
        next_cycle();
        set_req(3, 14'hC3, 1'b1, 1'b1);
        @(negedge clk);
        check("bp B", 128'(out_data), 128'(mk(14'hB2, 1'b1, 1'b1)));
        check("bp B valid", 128'(out_valid), 128'(1));
        next_cycle();
        in_valid = '0;
        @(negedge clk);
        check("bp C", 128'(out_data), 128'(mk(14'hC3, 1'b1, 1'b1)));
        check("bp C valid", 128'(out_valid), 128'(1));
        check("bp idle in_ready", 128'(in_ready), 128'(0));
        next_cycle();
        @(negedge clk);
        check("bp drained", 128'(out_valid), 128'(0));

        // Async reset between edges while req2 owns the lock.
        sync_reset();
        in_valid = 4'h4;
        set_req(2, 14'h2A, 1'b1, 1'b0);
        @(negedge clk);
        check("ar sop in_ready", 128'(in_ready), 128'(4'h4));
        next_cycle();
        in_valid = 4'h5;
        set_req(2, 14'h2B, 1'b0, 1'b0);
        set_req(0, 14'h10, 1'b1, 1'b1);
        #2;
        check("ar locked in_ready", 128'(in_ready), 128'(4'h4));
        check("ar pre out_valid", 128'(out_valid), 128'(1));
        reset = 1'b1;
        set_req(2, 14'h2C, 1'b1, 1'b1);
        #1;
        check("ar out_valid", 128'(out_valid), 128'(0));
        check("ar in_ready", 128'(in_ready), 128'(0));
        check("ar out_data", 128'(out_data), 128'(0));
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("ar release in_ready", 128'(in_ready), 128'(4'h1));
        next_cycle();
        @(negedge clk);
        check("ar first out_valid", 128'(out_valid), 128'(1));
        check("ar first out_sel", 128'(out_sel), 128'(0));
        check("ar first out_data", 128'(out_data), 128'(mk(14'h10, 1'b1, 1'b1)));
        check("ar next in_ready", 128'(in_ready), 128'(4'h4));

`ifdef VX_COMMIT_ARB_PERF_EN
        // 7 stalled cycles, then three single-beat commits.
        sync_reset();
        check("perf stall reset", 128'(perf_stall_cycles), 128'(0));
        check("perf commits reset", 128'(perf_commits), 128'(0));
        out_ready = 1'b0;
        in_valid  = 4'h1;
        set_req(0, 14'h50, 1'b1, 1'b1);
        next_cycle();
        set_req(0, 14'h51, 1'b1, 1'b1);
        for (int c = 2; c <= 7; c++) begin
            next_cycle();
        end
        next_cycle();
        out_ready = 1'b1;
        next_cycle();
        set_req(0, 14'h52, 1'b1, 1'b1);
        next_cycle();
        in_valid = '0;
        next_cycle();
        @(negedge clk);
        check("perf stall", 128'(perf_stall_cycles), 128'(7));
        check("perf commits", 128'(perf_commits), 128'(3));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
